// File: rtl/mem_arbiter_rr.sv
// rtl/mem_arbiter_rr.sv - round-robin arbiter sharing one single-port synchronous RAM among NREQ cores
//
// Purpose:
//   Lets NREQ cores take turns on a single-port synchronous RAM. Each
//   transaction runs IDLE -> ISSUE -> (WAIT x RD_LATENCY) -> DONE -> IDLE.
//   The grant rotates starting from the requester after the last one served.
//
// Ports:
//   clk, rst          core clock, asynchronous active-high reset
//   rden, wren        per-requester read / write request levels (write wins)
//   addr, din         per-requester address / write data, slot i at [i*W +: W]
//   dq                per-requester registered read data
//   ack               one-cycle completion pulse, shown during DONE
//   acq               one-hot ownership flag, high from ISSUE through DONE
//   busy              high whenever the arbiter is not in IDLE
//   ram_addr, ram_din, ram_wren, ram_q   RAM side

module mem_arbiter_rr #(
    parameter int NREQ       = 2,
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    rden,
    input  logic [NREQ-1:0]    wren,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] din,
    output logic [NREQ*DW-1:0] dq,
    output logic [NREQ-1:0]    ack,
    output logic [NREQ-1:0]    acq,
    output logic               busy,
    output logic [AW-1:0]      ram_addr,
    output logic [DW-1:0]      ram_din,
    output logic               ram_wren,
    input  logic [DW-1:0]      ram_q
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(RD_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [GW-1:0]   grant;
    logic [GW-1:0]   last_grant;
    logic [CW-1:0]   wait_cnt;
    logic            is_write;

    logic [NREQ-1:0] req;
    logic [GW-1:0]   pick;
    logic            pick_valid;
    logic [GW-1:0]   cand;
    int              sel_idx;

    assign req = rden | wren;

    function automatic logic [NREQ-1:0] onehot(input logic [GW-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Rotating priority search. Offsets are walked from the farthest to the
    // nearest so the requester closest after last_grant overwrites the rest.
    always_comb begin
        pick       = last_grant;
        pick_valid = 1'b0;
        sel_idx    = 0;
        cand       = '0;
        for (int k = NREQ; k >= 1; k--) begin
            sel_idx = (int'(last_grant) + k) % NREQ;
            cand    = GW'(sel_idx);
            if (req[cand]) begin
                pick       = cand;
                pick_valid = 1'b1;
            end
        end
    end

    // All outputs are registered: the values for a state are loaded on the
    // edge that enters that state, so they are valid throughout its cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= GW'(NREQ - 1);
            wait_cnt   <= '0;
            is_write   <= 1'b0;
            ack        <= '0;
            acq        <= '0;
            busy       <= 1'b0;
            ram_addr   <= '0;
            ram_din    <= '0;
            ram_wren   <= 1'b0;
            dq         <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant      <= pick;
                        last_grant <= pick;
                        is_write   <= wren[pick];
                        acq        <= onehot(pick);
                        busy       <= 1'b1;
                        ram_addr   <= addr[pick*AW +: AW];
                        ram_din    <= din[pick*DW +: DW];
                        ram_wren   <= wren[pick];
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // The RAM samples address/write enable on this edge.
                    ram_wren <= 1'b0;
                    if (is_write) begin
                        ack   <= onehot(grant);
                        state <= DONE;
                    end else begin
                        wait_cnt <= CW'(RD_LATENCY - 1);
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        dq[grant*DW +: DW] <= ram_q;
                        ack                <= onehot(grant);
                        state              <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                DONE: begin
                    // Always pass through IDLE so a requester still holding
                    // its request during the ack cycle is not served twice.
                    acq   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb/tb_mem_arbiter_rr.sv - directed scoreboard bench for mem_arbiter_rr
//
// Two instances: u_dut2 (NREQ=2, RD_LATENCY=1) and u_dut4 (NREQ=4, RD_LATENCY=3),
// each with a behavioural synchronous RAM. Expected completions are queued when
// a request is driven and popped when the arbiter pulses ack.

module tb_mem_arbiter_rr;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    typedef struct {
        int         req;
        bit         rd;
        logic [7:0] addr;
        logic [7:0] data;
        int         lat;
    } exp_t;

    exp_t sb2[$];
    exp_t sb4[$];

    // ---------------- 2-requester instance, RD_LATENCY = 1 ----------------
    logic [1:0]  r2_rden = '0;
    logic [1:0]  r2_wren = '0;
    logic [15:0] r2_addr = '0;
    logic [15:0] r2_din  = '0;
    logic [15:0] r2_dq;
    logic [1:0]  r2_ack;
    logic [1:0]  r2_acq;
    logic        r2_busy;
    logic [7:0]  r2_ram_addr;
    logic [7:0]  r2_ram_din;
    logic        r2_ram_wren;
    logic [7:0]  r2_ram_q;

    mem_arbiter_rr #(.NREQ(2), .AW(8), .DW(8), .RD_LATENCY(1)) u_dut2 (
        .clk      (clk),
        .rst      (rst),
        .rden     (r2_rden),
        .wren     (r2_wren),
        .addr     (r2_addr),
        .din      (r2_din),
        .dq       (r2_dq),
        .ack      (r2_ack),
        .acq      (r2_acq),
        .busy     (r2_busy),
        .ram_addr (r2_ram_addr),
        .ram_din  (r2_ram_din),
        .ram_wren (r2_ram_wren),
        .ram_q    (r2_ram_q)
    );

    logic [7:0] mem2 [256];
    logic [7:0] pipe2;
    always @(posedge clk) begin
        if (r2_ram_wren) mem2[r2_ram_addr] <= r2_ram_din;
        pipe2 <= mem2[r2_ram_addr];
    end
    assign r2_ram_q = pipe2;

    // ---------------- 4-requester instance, RD_LATENCY = 3 ----------------
    logic [3:0]  r4_rden = '0;
    logic [3:0]  r4_wren = '0;
    logic [31:0] r4_addr = '0;
    logic [31:0] r4_din  = '0;
    logic [31:0] r4_dq;
    logic [3:0]  r4_ack;
    logic [3:0]  r4_acq;
    logic        r4_busy;
    logic [7:0]  r4_ram_addr;
    logic [7:0]  r4_ram_din;
    logic        r4_ram_wren;
    logic [7:0]  r4_ram_q;

    mem_arbiter_rr #(.NREQ(4), .AW(8), .DW(8), .RD_LATENCY(3)) u_dut4 (
        .clk      (clk),
        .rst      (rst),
        .rden     (r4_rden),
        .wren     (r4_wren),
        .addr     (r4_addr),
        .din      (r4_din),
        .dq       (r4_dq),
        .ack      (r4_ack),
        .acq      (r4_acq),
        .busy     (r4_busy),
        .ram_addr (r4_ram_addr),
        .ram_din  (r4_ram_din),
        .ram_wren (r4_ram_wren),
        .ram_q    (r4_ram_q)
    );

    logic [7:0] mem4 [256];
    logic [7:0] pipe4 [3];
    always @(posedge clk) begin
        if (r4_ram_wren) mem4[r4_ram_addr] <= r4_ram_din;
        pipe4[0] <= mem4[r4_ram_addr];
        pipe4[1] <= pipe4[0];
        pipe4[2] <= pipe4[1];
    end
    assign r4_ram_q = pipe4[2];

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input int req, input bit rd, input logic [7:0] a,
                                input logic [7:0] d, input int lat);
        exp_t e;
        e.req  = req;
        e.rd   = rd;
        e.addr = a;
        e.data = d;
        e.lat  = lat;
        return e;
    endfunction

    // k0 = negedges already elapsed since the request was driven (or since
    // the previous ack); the ack must arrive at negedge count e.lat.
    task automatic wait_ack2(input int k0);
        int   k;
        bit   seen;
        bit   prev_acq;
        exp_t e;
        k        = k0;
        seen     = 1'b0;
        prev_acq = (r2_acq != '0);
        while (!seen && k < k0 + 20) begin
            @(negedge clk);
            k++;
            check("acq2_onehot", 32'($onehot0(r2_acq)), 32'd1);
            if (r2_acq != '0 && sb2.size() > 0) check("ram_addr2_held", r2_ram_addr, sb2[0].addr);
            if (r2_acq != '0 && prev_acq) check("ram_wren2_low", r2_ram_wren, 0);
            prev_acq = (r2_acq != '0);
            if (r2_ack != '0) seen = 1'b1;
        end
        n_checks++;
        assert (seen) n_pass++;
        else begin
            n_fail++;
            $error("FAIL ack2_timeout: observed no ack expected ack within 20 cycles");
            return;
        end
        n_checks++;
        assert (sb2.size() > 0) n_pass++;
        else begin
            n_fail++;
            $error("FAIL ack2_unexpected: observed ack 0x%0h expected none", r2_ack);
            return;
        end
        e = sb2.pop_front();
        check("ack2_who", r2_ack, 1 << e.req);
        check("acq2_at_done", r2_acq, 1 << e.req);
        check("ack2_latency", k, e.lat);
        if (e.rd) check("dq2_value", r2_dq[e.req*8 +: 8], e.data);
    endtask

    task automatic wait_ack4(input int k0);
        int   k;
        bit   seen;
        bit   prev_acq;
        exp_t e;
        k        = k0;
        seen     = 1'b0;
        prev_acq = (r4_acq != '0);
        while (!seen && k < k0 + 20) begin
            @(negedge clk);
            k++;
            check("acq4_onehot", 32'($onehot0(r4_acq)), 32'd1);
            if (r4_acq != '0 && sb4.size() > 0) check("ram_addr4_held", r4_ram_addr, sb4[0].addr);
            if (r4_acq != '0 && prev_acq) check("ram_wren4_low", r4_ram_wren, 0);
            prev_acq = (r4_acq != '0);
            if (r4_ack != '0) seen = 1'b1;
        end
        n_checks++;
        assert (seen) n_pass++;
        else begin
            n_fail++;
            $error("FAIL ack4_timeout: observed no ack expected ack within 20 cycles");
            return;
        end
        n_checks++;
        assert (sb4.size() > 0) n_pass++;
        else begin
            n_fail++;
            $error("FAIL ack4_unexpected: observed ack 0x%0h expected none", r4_ack);
            return;
        end
        e = sb4.pop_front();
        check("ack4_who", r4_ack, 1 << e.req);
        check("acq4_at_done", r4_acq, 1 << e.req);
        check("ack4_latency", k, e.lat);
        if (e.rd) check("dq4_value", r4_dq[e.req*8 +: 8], e.data);
    endtask

    // Single-requester transaction: drive, check the ISSUE cycle, wait for ack, release.
    task automatic txn2(input int c, input bit rd, input bit wr, input logic [7:0] a,
                        input logic [7:0] d, input logic [7:0] exp_dq, input int lat);
        @(negedge clk);
        r2_rden[c]        = rd;
        r2_wren[c]        = wr;
        r2_addr[c*8 +: 8] = a;
        r2_din[c*8 +: 8]  = d;
        sb2.push_back(mk(c, rd && !wr, a, exp_dq, lat));
        @(negedge clk);
        check("issue2_acq", r2_acq, 1 << c);
        check("issue2_busy", r2_busy, 1);
        check("issue2_wren", r2_ram_wren, wr);
        check("issue2_ack_low", r2_ack, 0);
        if (wr) check("issue2_din", r2_ram_din, d);
        wait_ack2(1);
        r2_rden[c] = 1'b0;
        r2_wren[c] = 1'b0;
        if (wr) check("mem2_written", mem2[a], d);
    endtask

    task automatic txn4(input int c, input bit rd, input bit wr, input logic [7:0] a,
                        input logic [7:0] d, input logic [7:0] exp_dq, input int lat);
        @(negedge clk);
        r4_rden[c]        = rd;
        r4_wren[c]        = wr;
        r4_addr[c*8 +: 8] = a;
        r4_din[c*8 +: 8]  = d;
        sb4.push_back(mk(c, rd && !wr, a, exp_dq, lat));
        @(negedge clk);
        check("issue4_acq", r4_acq, 1 << c);
        check("issue4_busy", r4_busy, 1);
        check("issue4_wren", r4_ram_wren, wr);
        check("issue4_ack_low", r4_ack, 0);
        if (wr) check("issue4_din", r4_ram_din, d);
        wait_ack4(1);
        r4_rden[c] = 1'b0;
        r4_wren[c] = 1'b0;
        if (wr) check("mem4_written", mem4[a], d);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $error("FAIL watchdog: observed no finish expected finish before 100000 ns");
        $fatal(1);
    end

    initial begin
        // Reset state
        @(negedge clk);
        check("rst2_busy", r2_busy, 0);
        check("rst2_ack", r2_ack, 0);
        check("rst2_acq", r2_acq, 0);
        check("rst2_wren", r2_ram_wren, 0);
        check("rst2_addr", r2_ram_addr, 0);
        check("rst2_din", r2_ram_din, 0);
        check("rst2_dq", r2_dq, 0);
        check("rst4_busy", r4_busy, 0);
        check("rst4_acq", r4_acq, 0);
        check("rst4_dq", r4_dq, 0);
        rst = 1'b0;

        // 1: write then read back on the 2-core instance
        txn2(0, 1'b0, 1'b1, 8'h10, 8'hA5, 8'h00, 2);
        check("t1_wren_cleared", r2_ram_wren, 0);
        check("t1_addr", r2_ram_addr, 8'h10);
        txn2(0, 1'b1, 1'b0, 8'h10, 8'h00, 8'hA5, 3);
        @(negedge clk);
        check("t1_busy_idle", r2_busy, 0);
        check("t1_acq_idle", r2_acq, 0);

        // 5: read+write together behaves as a write and leaves dq alone
        txn2(0, 1'b1, 1'b1, 8'h20, 8'h77, 8'h00, 2);
        check("t5_dq0_kept", r2_dq[7:0], 8'hA5);

        // 2: continuous reads from both cores alternate 0,1,0,1 from reset
        txn2(0, 1'b0, 1'b1, 8'h40, 8'h11, 8'h00, 2);
        txn2(1, 1'b0, 1'b1, 8'h41, 8'h22, 8'h00, 2);
        pulse_reset();
        @(negedge clk);
        r2_addr = {8'h41, 8'h40};
        r2_rden = 2'b11;
        sb2.push_back(mk(0, 1'b1, 8'h40, 8'h11, 3));
        sb2.push_back(mk(1, 1'b1, 8'h41, 8'h22, 4));
        sb2.push_back(mk(0, 1'b1, 8'h40, 8'h11, 4));
        sb2.push_back(mk(1, 1'b1, 8'h41, 8'h22, 4));
        wait_ack2(0);
        wait_ack2(0);
        wait_ack2(0);
        wait_ack2(0);
        r2_rden = 2'b00;
        check("t2_sb_empty", sb2.size(), 0);

        // Preload the 4-core RAM through core 0
        txn4(0, 1'b0, 1'b1, 8'h33, 8'h3C, 8'h00, 2);
        txn4(0, 1'b0, 1'b1, 8'h51, 8'h5A, 8'h00, 2);
        txn4(0, 1'b0, 1'b1, 8'h53, 8'hC3, 8'h00, 2);

        // 4: RD_LATENCY=3 read by core 2, ram_addr held through the WAIT cycles
        txn4(2, 1'b1, 1'b0, 8'h33, 8'h00, 8'h3C, 5);

        // 3: only cores 1 and 3 request; after a grant to 1 the order is 3,1,3
        pulse_reset();
        txn4(1, 1'b1, 1'b0, 8'h51, 8'h00, 8'h5A, 5);
        @(negedge clk);
        r4_addr = {8'h53, 8'h00, 8'h51, 8'h00};
        r4_rden = 4'b1010;
        sb4.push_back(mk(3, 1'b1, 8'h53, 8'hC3, 5));
        sb4.push_back(mk(1, 1'b1, 8'h51, 8'h5A, 6));
        sb4.push_back(mk(3, 1'b1, 8'h53, 8'hC3, 6));
        wait_ack4(0);
        wait_ack4(0);
        wait_ack4(0);
        r4_rden = 4'b0000;
        check("t3_sb_empty", sb4.size(), 0);

        // 6: reset during WAIT of a core-1 read
        @(negedge clk);
        r4_addr[15:8] = 8'h51;
        r4_rden[1]    = 1'b1;
        @(negedge clk);
        check("t6_issue_acq", r4_acq, 4'b0010);
        @(negedge clk);
        check("t6_in_wait", r4_busy, 1);
        rst = 1'b1;
        #1;
        check("t6_rst_ack", r4_ack, 0);
        check("t6_rst_acq", r4_acq, 0);
        check("t6_rst_busy", r4_busy, 0);
        check("t6_rst_addr", r4_ram_addr, 0);
        check("t6_rst_wren", r4_ram_wren, 0);
        check("t6_rst_dq", r4_dq, 0);
        r4_rden = 4'b0000;
        @(negedge clk);
        check("t6_no_ack", r4_ack, 0);
        rst = 1'b0;
        @(negedge clk);
        check("t6_idle_after", r4_busy, 0);
        txn4(0, 1'b1, 1'b0, 8'h33, 8'h00, 8'h3C, 5);
        check("t6_sb_empty", sb4.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- Parametrised round-robin arbiter that lets NREQ cores share one single-port synchronous RAM (IRAM or DRAM).
- Successor to the fixed two-core memory controller. It scales to N requesters and configurable address/data widths.
- Adds fair rotation, a per-transaction ack pulse, and configurable RAM read latency.
- One instance sits between the cores and each RAM; clocked by the divided core clock.

Parameters:
- NREQ, 2, number of requesting cores (2..8).
- AW, 8, address width.
- DW, 8, data width.
- RD_LATENCY, 1, RAM cycles from address-clock edge to valid q (1..4).

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous active-high reset.
- rden  in  NREQ  per-requester read request, level.
- wren  in  NREQ  per-requester write request, level.
- addr  in  NREQ*AW  requester i at [i*AW +: AW].
- din  in  NREQ*DW  write data, requester i at [i*DW +: DW].
- dq  out  NREQ*DW  registered read data, requester i at [i*DW +: DW].
- ack  out  NREQ  one-cycle completion pulse per requester.
- acq  out  NREQ  one-hot; high while requester i owns the RAM (ISSUE..DONE).
- busy  out  1  high in any state other than IDLE.
- ram_addr  out  AW  to RAM address.
- ram_din  out  DW  to RAM data.
- ram_wren  out  1  to RAM write enable.
- ram_q  in  DW  RAM read data.

Behaviour:
- Reset (async, any state):
  - State = IDLE.
  - ack, acq, ram_wren, busy = 0; ram_addr, ram_din, dq = 0.
  - last_grant = NREQ-1, so requester 0 has first priority.
- Request rule: req[i] = rden[i] | wren[i]. Requester holds addr/din/rden/wren stable until it samples ack[i]=1, then deasserts in the following cycle.
- If rden[i] and wren[i] are both high, the write wins and the read is ignored.
- IDLE:
  - With no requests, stay in IDLE.
  - Otherwise pick the first i with req[i]=1, searching last_grant+1, +2, ... modulo NREQ.
  - Register g=i and last_grant=i; go to ISSUE.
- ISSUE (1 cycle):
  - acq[g]=1; ram_addr=addr[g]; ram_din=din[g]; ram_wren=wren[g].
  - Write: next state DONE. Read: next state WAIT with wait counter = RD_LATENCY-1.
- WAIT:
  - ram_addr held, ram_wren=0.
  - When the counter reaches 0, capture ram_q into dq slot g at the clock edge and go to DONE; otherwise decrement.
- DONE (1 cycle):
  - ack[g]=1, acq[g] still 1, ram_wren=0.
  - Always return to IDLE, never directly to another grant, so a stale request is never re-served.
- Latency, counted from the IDLE sampling edge to the ack-high cycle:
  - Write: ISSUE, DONE → ack in the 2nd cycle.
  - Read: ISSUE, WAIT×RD_LATENCY, DONE → ack in cycle 2+RD_LATENCY.
  - Each transaction occupies its cycles plus 1 IDLE cycle.
- dq slots hold their value until that requester's next read completes. Writes never modify dq.
- Fairness: a continuously requesting core is granted within NREQ transactions.
- ack and acq are never high for more than one requester.
- Requests arriving during ISSUE/WAIT/DONE wait; they are evaluated in the next IDLE.
- Reset mid-transaction: the RAM write (if any) is aborted and no ack is produced. The requester must re-issue after reset.

Test Plan:
1. Reset with NREQ=2, RD_LATENCY=1; req0 writes addr 0x10 with data 0xA5 → ram_wren=1 with ram_addr=0x10 for one cycle; ack[0] pulses 2 cycles after sampling. A later read of 0x10 returns dq0=0xA5, with ack[0] 3 cycles after sampling.
2. Both cores request reads continuously from reset → grants alternate 0,1,0,1. Never two consecutive grants to one core while the other requests; acq stays one-hot.
3. NREQ=4, only cores 1 and 3 request; last_grant=1 → next grant is 3, then 1. Cores 0 and 2 are skipped with no idle gaps beyond the mandatory IDLE cycle.
4. RD_LATENCY=3: read of a preloaded address holding 0x3C → ack 5 cycles after sampling, dq=0x3C. ram_addr is stable across all WAIT cycles.
5. Core 0 asserts rden and wren together (addr 0x20, din 0x77) → treated as a write: ram_wren=1, dq0 unchanged.
6. Assert rst during WAIT of a read by core 1 → outputs clear immediately with no ack[1]. After release, core 0 requesting alone is granted first.
